// File: rtl/branch_update_sched_pkg.sv
// Shared types for the branch predictor update path:
// counters, update FIFO entries and the RMW state.
package lc3b_types;

   typedef logic [8:0] lc3b_offset9;
   typedef logic [1:0] bpred_cnt_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      WR   = 2'd2
   } bupd_state_t;

   typedef struct packed {
      lc3b_offset9 index;
      logic        taken;
   } bupd_entry_t;

   // 2-bit saturating counter step
   function automatic bpred_cnt_t bpred_next(
      input bpred_cnt_t c,
      input logic       taken
   );
      if (taken)
         return (c == 2'b11) ? c : c + 2'b01;
      return (c == 2'b00) ? c : c - 2'b01;
   endfunction

endpackage

// File: rtl/branch_update_sched_fifo.sv
// Small FIFO holding resolved branch updates until
// the shared BHT/PHT port is free.
module branch_update_fifo
   import lc3b_types::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   i_push,
   input  bupd_entry_t            i_data,
   input  logic                   i_pop,
   output bupd_entry_t            o_head,
   output logic [$clog2(DEPTH):0] o_count,
   output logic                   o_full,
   output logic                   o_empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   bupd_entry_t   r_mem [DEPTH];
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [CW-1:0] r_count;
   logic          w_push;
   logic          w_pop;

   assign o_full  = (r_count == CW'(DEPTH));
   assign o_empty = (r_count == '0);
   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;
   assign o_head  = r_mem[r_rptr];
   assign o_count = r_count;

   always_ff @(posedge clk) begin
      if (w_push)
         r_mem[r_wptr] <= i_data;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push)
            r_wptr <= r_wptr + AW'(1);
         if (w_pop)
            r_rptr <= r_rptr + AW'(1);
         unique case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/branch_update_sched.sv
// Arbitrates the single BHT/PHT port between fetch
// lookups and buffered read-modify-write updates.
module branch_update_sched
   import lc3b_types::*;
#(
   parameter int FIFO_DEPTH   = 4,
   parameter int PHT_IDX_W    = 9,
   parameter int STARVE_LIMIT = 8
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 lookup_req,
   input  lc3b_offset9          lookup_index,
   output logic                 lookup_ack,
   output logic                 pred_valid,
   output logic                 pred_taken,
   input  logic                 upd_valid,
   input  lc3b_offset9          upd_index,
   input  logic                 upd_taken,
   output logic                 upd_ready,
   output lc3b_offset9          bht_index,
   output logic                 bht_load,
   output logic                 bht_branch_enable,
   input  logic [15:0]          bht_out,
   output logic [PHT_IDX_W-1:0] pht_index,
   output logic                 pht_we,
   output bpred_cnt_t           pht_wdata,
   input  bpred_cnt_t           pht_rdata
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int SW = $clog2(STARVE_LIMIT + 1);

   function automatic logic [PHT_IDX_W-1:0] pht_hash(
      input logic [15:0] hist,
      input lc3b_offset9 idx
   );
      return hist[PHT_IDX_W-1:0] ^ PHT_IDX_W'(idx);
   endfunction

   bupd_state_t          r_state;
   bupd_state_t          w_next;
   logic [SW-1:0]        r_starve;
   logic [PHT_IDX_W-1:0] r_pidx;
   bpred_cnt_t           r_cnt;
   logic                 r_pred_valid;
   logic                 r_pred_taken;
   bupd_entry_t          w_head;
   bupd_entry_t          w_in;
   logic [CW-1:0]        w_count;
   logic                 w_full;
   logic                 w_empty;
   logic                 w_fifo_ne;
   logic                 w_upd_pri;
   logic                 w_lk_win;
   logic                 w_push;
   logic                 w_pop;
   logic                 w_unused;

   assign w_unused   = ^bht_out[15:PHT_IDX_W];
   assign w_in       = '{index: upd_index, taken: upd_taken};
   assign upd_ready  = !w_full;
   assign w_push     = upd_valid && upd_ready;
   assign w_pop      = (r_state == WR);
   assign w_fifo_ne  = !w_empty;
   assign w_upd_pri  = w_fifo_ne && (r_starve == SW'(STARVE_LIMIT));
   assign w_lk_win   = lookup_req && !w_upd_pri && (r_state != WR);
   assign lookup_ack = w_lk_win;
   assign pred_valid = r_pred_valid;
   assign pred_taken = r_pred_taken;

   branch_update_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .i_push  (w_push),
      .i_data  (w_in),
      .i_pop   (w_pop),
      .o_head  (w_head),
      .o_count (w_count),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         r_state <= IDLE;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE: if (w_fifo_ne && !w_lk_win) w_next = RD;
         RD:   w_next = w_lk_win ? IDLE : WR;
         WR:   w_next = (w_count > CW'(1) && !lookup_req) ? RD : IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_comb begin
      bht_index         = '0;
      bht_load          = 1'b0;
      bht_branch_enable = 1'b0;
      pht_index         = '0;
      pht_we            = 1'b0;
      pht_wdata         = 2'b00;
      if (w_lk_win) begin
         bht_index = lookup_index;
         pht_index = pht_hash(bht_out, lookup_index);
      end else begin
         unique case (r_state)
            RD: begin
               bht_index = w_head.index;
               pht_index = pht_hash(bht_out, w_head.index);
            end
            WR: begin
               bht_index         = w_head.index;
               bht_load          = 1'b1;
               bht_branch_enable = w_head.taken;
               pht_index         = r_pidx;
               pht_we            = 1'b1;
               pht_wdata         = bpred_next(r_cnt, w_head.taken);
            end
            default: ;
         endcase
      end
   end

   // starve count only grows while an update is actually waiting
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_starve     <= '0;
         r_pidx       <= '0;
         r_cnt        <= 2'b00;
         r_pred_valid <= 1'b0;
         r_pred_taken <= 1'b0;
      end else begin
         if (r_state == RD && !w_lk_win) begin
            r_starve <= '0;
            r_pidx   <= pht_hash(bht_out, w_head.index);
            r_cnt    <= pht_rdata;
         end else if (w_lk_win && w_fifo_ne) begin
            r_starve <= r_starve + SW'(1);
         end
         r_pred_valid <= w_lk_win;
         r_pred_taken <= w_lk_win & pht_rdata[1];
      end
   end

endmodule

// File: tb/tb_branch_update_sched.sv
// Bench for branch_update_sched: directed scenarios plus a
// randomized run checked against an in-order table model.
module tb_branch_update_sched;

   logic        clk;
   logic        reset_n;
   logic        lookup_req;
   logic [8:0]  lookup_index;
   logic        lookup_ack;
   logic        pred_valid;
   logic        pred_taken;
   logic        upd_valid;
   logic [8:0]  upd_index;
   logic        upd_taken;
   logic        upd_ready;
   logic [8:0]  bht_index;
   logic        bht_load;
   logic        bht_branch_enable;
   logic [15:0] bht_out;
   logic [8:0]  pht_index;
   logic        pht_we;
   logic [1:0]  pht_wdata;
   logic [1:0]  pht_rdata;

   int total;
   int bad;

   logic [15:0] bht_mem [512];
   logic [1:0]  pht_mem [512];
   logic [15:0] m_bht [512];
   logic [1:0]  m_pht [512];

   branch_update_sched dut (
      .clk               (clk),
      .reset_n           (reset_n),
      .lookup_req        (lookup_req),
      .lookup_index      (lookup_index),
      .lookup_ack        (lookup_ack),
      .pred_valid        (pred_valid),
      .pred_taken        (pred_taken),
      .upd_valid         (upd_valid),
      .upd_index         (upd_index),
      .upd_taken         (upd_taken),
      .upd_ready         (upd_ready),
      .bht_index         (bht_index),
      .bht_load          (bht_load),
      .bht_branch_enable (bht_branch_enable),
      .bht_out           (bht_out),
      .pht_index         (pht_index),
      .pht_we            (pht_we),
      .pht_wdata         (pht_wdata),
      .pht_rdata         (pht_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign bht_out   = bht_mem[bht_index];
   assign pht_rdata = pht_mem[pht_index];

   always @(posedge clk) begin
      if (bht_load)
         bht_mem[bht_index] <= {bht_mem[bht_index][14:0], bht_branch_enable};
      if (pht_we)
         pht_mem[pht_index] <= pht_wdata;
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_tables();
      for (int i = 0; i < 512; i++) begin
         bht_mem[i] <= 16'h0000;
         pht_mem[i] <= 2'b00;
      end
   endtask

   task automatic push(input logic [8:0] idx, input logic t);
      upd_valid = 1'b1;
      upd_index = idx;
      upd_taken = t;
      cyc();
      upd_valid = 1'b0;
   endtask

   task automatic wait_we(
      input  int         lim,
      output bit         found,
      output logic [1:0] wd,
      output logic [8:0] pi
   );
      found = 1'b0;
      wd    = 2'b00;
      pi    = 9'h000;
      for (int i = 0; i < lim && !found; i++) begin
         @(negedge clk);
         if (pht_we) begin
            found = 1'b1;
            wd    = pht_wdata;
            pi    = pht_index;
         end else begin
            cyc();
         end
      end
   endtask

   task automatic test_reset();
      logic [5:0] obs;
      reset_n      = 1'b0;
      lookup_req   = 1'b0;
      lookup_index = '0;
      upd_valid    = 1'b0;
      upd_index    = '0;
      upd_taken    = 1'b0;
      clear_tables();
      #3;
      obs = {lookup_ack, pred_valid, pred_taken, bht_load, pht_we, upd_ready};
      total++;
      if (obs !== 6'b000001) begin
         bad++;
         $display("FAIL reset_in: got %b want 000001", obs);
      end
      cyc();
      cyc();
      reset_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         obs = {lookup_ack, pred_valid, pred_taken, bht_load, pht_we, upd_ready};
         total++;
         if (obs !== 6'b000001) begin
            bad++;
            $display("FAIL reset_idle c%0d: got %b want 000001", i, obs);
         end
         cyc();
      end
   endtask

   task automatic test_single_update();
      logic [12:0] obs;
      clear_tables();
      pht_mem[9'h005] <= 2'b01;
      cyc();
      push(9'h005, 1'b1);
      @(negedge clk);
      total++;
      if ({bht_load, pht_we} !== 2'b00) begin
         bad++;
         $display("FAIL single_idle: got %b want 00", {bht_load, pht_we});
      end
      cyc();
      @(negedge clk);
      obs = {pht_index, bht_load, pht_we, 2'b00};
      total++;
      if (obs !== {9'h005, 4'b0000}) begin
         bad++;
         $display("FAIL single_rd: got %h want %h", obs, {9'h005, 4'b0000});
      end
      cyc();
      @(negedge clk);
      obs = {pht_index, pht_wdata, pht_we, bht_load};
      total++;
      if (obs !== {9'h005, 2'b10, 2'b11} || bht_branch_enable !== 1'b1) begin
         bad++;
         $display("FAIL single_wr: got %h en=%b want %h en=1",
                  obs, bht_branch_enable, {9'h005, 2'b10, 2'b11});
      end
      cyc();
      @(negedge clk);
      total++;
      if ({bht_load, pht_we} !== 2'b00 || pht_mem[9'h005] !== 2'b10
          || bht_mem[9'h005] !== 16'h0001) begin
         bad++;
         $display("FAIL single_done: we=%b pht=%b bht=%h want 0 10 0001",
                  pht_we, pht_mem[9'h005], bht_mem[9'h005]);
      end
      cyc();
   endtask

   task automatic test_saturation();
      bit         f;
      logic [1:0] wd;
      logic [8:0] pi;
      clear_tables();
      pht_mem[9'h033] <= 2'b11;
      pht_mem[9'h044] <= 2'b00;
      cyc();
      push(9'h033, 1'b1);
      wait_we(8, f, wd, pi);
      total++;
      if (!f || wd !== 2'b11 || pi !== 9'h033) begin
         bad++;
         $display("FAIL sat_hi: found=%0d wd=%b idx=%h want 1 11 033", f, wd, pi);
      end
      cyc();
      push(9'h044, 1'b0);
      wait_we(8, f, wd, pi);
      total++;
      if (!f || wd !== 2'b00 || pi !== 9'h044) begin
         bad++;
         $display("FAIL sat_lo: found=%0d wd=%b idx=%h want 1 00 044", f, wd, pi);
      end
      cyc();
      cyc();
   endtask

   task automatic test_lookup();
      clear_tables();
      bht_mem[9'h0A0] <= 16'h0003;
      pht_mem[9'h0A3] <= 2'b11;
      cyc();
      lookup_req   = 1'b1;
      lookup_index = 9'h0A0;
      @(negedge clk);
      total++;
      if (lookup_ack !== 1'b1 || bht_index !== 9'h0A0 || pht_index !== 9'h0A3) begin
         bad++;
         $display("FAIL lookup_addr: ack=%b bht=%h pht=%h want 1 0a0 0a3",
                  lookup_ack, bht_index, pht_index);
      end
      cyc();
      lookup_req = 1'b0;
      @(negedge clk);
      total++;
      if ({pred_valid, pred_taken} !== 2'b11) begin
         bad++;
         $display("FAIL lookup_pred: got %b want 11", {pred_valid, pred_taken});
      end
      cyc();
      @(negedge clk);
      total++;
      if (pred_valid !== 1'b0) begin
         bad++;
         $display("FAIL lookup_noack: pred_valid=%b want 0", pred_valid);
      end
      cyc();
   endtask

   task automatic test_starve();
      logic [1:0] exp_tail [4];
      exp_tail[0] = 2'b00;
      exp_tail[1] = 2'b00;
      exp_tail[2] = 2'b01;
      exp_tail[3] = 2'b10;
      clear_tables();
      pht_mem[9'h010] <= 2'b01;
      cyc();
      lookup_req   = 1'b1;
      lookup_index = 9'h100;
      push(9'h010, 1'b1);
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         total++;
         if ({lookup_ack, pht_we} !== 2'b10) begin
            bad++;
            $display("FAIL starve_ack c%0d: ack/we=%b want 10", i, {lookup_ack, pht_we});
         end
         cyc();
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         total++;
         if ({lookup_ack, pht_we} !== exp_tail[i]) begin
            bad++;
            $display("FAIL starve_tail c%0d: ack/we=%b want %b",
                     9 + i, {lookup_ack, pht_we}, exp_tail[i]);
         end
         cyc();
      end
      lookup_req = 1'b0;
      @(negedge clk);
      total++;
      if (pht_mem[9'h010] !== 2'b10) begin
         bad++;
         $display("FAIL starve_write: pht=%b want 10", pht_mem[9'h010]);
      end
      cyc();
   endtask

   task automatic test_full();
      int n;
      clear_tables();
      cyc();
      lookup_req   = 1'b1;
      lookup_index = 9'h1FF;
      for (int i = 0; i < 4; i++)
         push(9'h020 + 9'(i), 1'b1);
      @(negedge clk);
      total++;
      if (upd_ready !== 1'b0) begin
         bad++;
         $display("FAIL full_ready: upd_ready=%b want 0", upd_ready);
      end
      cyc();
      upd_valid = 1'b1;
      upd_index = 9'h024;
      upd_taken = 1'b1;
      cyc();
      upd_valid  = 1'b0;
      lookup_req = 1'b0;
      n = 0;
      for (int i = 0; i < 24; i++) begin
         @(negedge clk);
         if (pht_we)
            n++;
         cyc();
      end
      total++;
      if (n != 4) begin
         bad++;
         $display("FAIL full_drain: writes=%0d want 4", n);
      end
      for (int i = 0; i < 5; i++) begin
         total++;
         if (pht_mem[9'h020 + 9'(i)] !== ((i < 4) ? 2'b01 : 2'b00)) begin
            bad++;
            $display("FAIL full_entry %0d: pht=%b want %b",
                     i, pht_mem[9'h020 + 9'(i)], (i < 4) ? 2'b01 : 2'b00);
         end
      end
   endtask

   task automatic test_reset_mid_wr();
      bit         f;
      logic [1:0] wd;
      logic [8:0] pi;
      int         n;
      clear_tables();
      cyc();
      push(9'h030, 1'b1);
      push(9'h031, 1'b1);
      wait_we(8, f, wd, pi);
      total++;
      if (!f) begin
         bad++;
         $display("FAIL rstwr_reach: no write seen, want one");
      end
      reset_n = 1'b0;
      #1;
      total++;
      if ({pht_we, bht_load, upd_ready, lookup_ack} !== 4'b0010) begin
         bad++;
         $display("FAIL rstwr_now: we/load/ready/ack=%b want 0010",
                  {pht_we, bht_load, upd_ready, lookup_ack});
      end
      cyc();
      reset_n = 1'b1;
      n = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (pht_we || bht_load)
            n++;
         cyc();
      end
      total++;
      if (n != 0 || pht_mem[9'h030] !== 2'b00 || pht_mem[9'h031] !== 2'b00) begin
         bad++;
         $display("FAIL rstwr_after: writes=%0d p30=%b p31=%b want 0 00 00",
                  n, pht_mem[9'h030], pht_mem[9'h031]);
      end
   endtask

   task automatic test_random();
      logic [9:0] q [$];
      logic       prev_ack;
      logic       prev_exp;
      int         nwe;
      logic [8:0] idx;
      logic [8:0] p;
      logic       t;
      logic [1:0] c;
      for (int i = 0; i < 512; i++) begin
         m_bht[i]   = 16'($urandom);
         m_pht[i]   = 2'($urandom);
         bht_mem[i] <= m_bht[i];
         pht_mem[i] <= m_pht[i];
      end
      cyc();
      prev_ack = 1'b0;
      prev_exp = 1'b0;
      nwe      = 0;
      for (int k = 0; k < 800; k++) begin
         lookup_req   = ($urandom_range(0, 9) < 6);
         lookup_index = 9'($urandom);
         upd_valid    = ($urandom_range(0, 1) == 1);
         upd_index    = 9'($urandom_range(0, 7));
         upd_taken    = 1'($urandom);
         @(negedge clk);
         if (upd_valid && upd_ready)
            q.push_back({upd_index, upd_taken});
         total++;
         if (pred_valid !== prev_ack || (prev_ack && pred_taken !== prev_exp)) begin
            bad++;
            $display("FAIL rnd_pred c%0d: v=%b t=%b want %b %b",
                     k, pred_valid, pred_taken, prev_ack, prev_exp);
         end
         total++;
         if (lookup_ack && (!lookup_req || pht_we || bht_load)) begin
            bad++;
            $display("FAIL rnd_port c%0d: ack=%b req=%b we=%b want exclusive",
                     k, lookup_ack, lookup_req, pht_we);
         end
         if (lookup_ack)
            prev_exp = pht_mem[pht_index][1];
         prev_ack = lookup_ack;
         if (pht_we)
            nwe++;
         cyc();
      end
      lookup_req = 1'b0;
      upd_valid  = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (pht_we)
            nwe++;
         cyc();
      end
      total++;
      if (nwe != q.size()) begin
         bad++;
         $display("FAIL rnd_count: writes=%0d want %0d", nwe, q.size());
      end
      foreach (q[j]) begin
         idx = q[j][9:1];
         t   = q[j][0];
         p   = m_bht[idx][8:0] ^ idx;
         c   = m_pht[p];
         if (t)
            m_pht[p] = (c == 2'b11) ? 2'b11 : c + 2'b01;
         else
            m_pht[p] = (c == 2'b00) ? 2'b00 : c - 2'b01;
         m_bht[idx] = {m_bht[idx][14:0], t};
      end
      for (int i = 0; i < 512; i++) begin
         total++;
         if (bht_mem[i] !== m_bht[i] || pht_mem[i] !== m_pht[i]) begin
            bad++;
            $display("FAIL rnd_table %0d: bht=%h pht=%b want %h %b",
                     i, bht_mem[i], pht_mem[i], m_bht[i], m_pht[i]);
         end
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_single_update();
      test_saturation();
      test_lookup();
      test_starve();
      test_full();
      test_reset_mid_wr();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

endmodule
